factorial: RTL and testbench

- Sequential iterative factorial engine: computes ain! using one multiply per clock, with no start handshake.
- Free-running: after reset it latches ain, computes, holds the result, and restarts whenever ain changes.
- Exposes the running product, the multiplication count, and a sticky overflow flag.
- Standalone arithmetic block; clock and reset come from the system clock/reset tree.

---
 rtl/factorial.sv | 133 +++++++++++++
 tb/tb_factorial.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/factorial.sv
// -----------------------------------------------------------------------------
// factorial
//
// Free-running iterative factorial engine. After reset it latches ain in IDLE,
// then performs one multiply per clock in CALC until counter reaches the
// latched n or the next product would not fit in OUT_W bits. The result is
// held in DONE until ain differs from the latched n, which restarts the
// computation through IDLE.
//
// Ports:
//   clock     in   1      system clock, rising-edge active
//   reset     in   1      asynchronous, active-high reset
//   ain       in   IN_W   operand n, sampled only in IDLE
//   counter   out  IN_W   multiplications completed (aout = counter!)
//   overflow  out  1      sticky; next product would exceed OUT_W bits
//   aout      out  OUT_W  running / final product
//   state_dbg out  2      current FSM state (IDLE=0, CALC=1, DONE=2)
//
// Handshake: there is no valid/ready pair. ain is a level, not a request; it
// is captured in IDLE and re-examined only in DONE. The outputs carry the
// final result for as long as state_dbg reports DONE; in CALC they show the
// running partial product k! with counter = k.
// -----------------------------------------------------------------------------
module factorial #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 21
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [IN_W-1:0]  ain,
  output logic [IN_W-1:0]  counter,
  output logic             overflow,
  output logic [OUT_W-1:0] aout,
  output logic [1:0]       state_dbg
);

  localparam int PROD_W = OUT_W + IN_W;
  localparam logic [IN_W-1:0]  ONE_N   = {{(IN_W-1){1'b0}}, 1'b1};
  localparam logic [OUT_W-1:0] ONE_OUT = {{(OUT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [IN_W-1:0]  n_q, n_d;
  logic [IN_W-1:0]  counter_q, counter_d;
  logic [OUT_W-1:0] aout_q, aout_d;
  logic             overflow_q, overflow_d;

  logic [IN_W-1:0]   count_inc;
  logic [PROD_W-1:0] prod;
  logic              prod_ovf;
  logic              at_n;

  // Single combinational multiply at full width so that any set bit above
  // OUT_W flags overflow before the product is committed.
  assign count_inc = counter_q + ONE_N;
  assign prod      = {{IN_W{1'b0}}, aout_q} * {{OUT_W{1'b0}}, count_inc};
  assign prod_ovf  = |prod[PROD_W-1:OUT_W];
  assign at_n      = (counter_q == n_q);

  // State and datapath registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      n_q        <= '0;
      counter_q  <= '0;
      aout_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      counter_q  <= counter_d;
      aout_q     <= aout_d;
      overflow_q <= overflow_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: state_d = S_CALC;
      S_CALC: begin
        if (at_n || prod_ovf) state_d = S_DONE;
      end
      S_DONE: begin
        if (ain != n_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath next values (all outputs are registered)
  always_comb begin
    n_d        = n_q;
    counter_d  = counter_q;
    aout_d     = aout_q;
    overflow_d = overflow_q;
    case (state_q)
      S_IDLE: begin
        n_d        = ain;
        counter_d  = '0;
        aout_d     = ONE_OUT;
        overflow_d = 1'b0;
      end
      S_CALC: begin
        if (!at_n) begin
          if (prod_ovf) begin
            // Keep the last representable product; counter stops here too,
            // so it can never wrap even for very large n.
            overflow_d = 1'b1;
          end else begin
            aout_d    = prod[OUT_W-1:0];
            counter_d = count_inc;
          end
        end
      end
      default: begin
        // DONE (and any illegal code) holds the datapath
      end
    endcase
  end

  assign counter   = counter_q;
  assign overflow  = overflow_q;
  assign aout      = aout_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_factorial.sv
`timescale 1ns/1ps
module tb_factorial;

  localparam int IN_W  = 16;
  localparam int OUT_W = 21;
  localparam int EXP_W = 1 + IN_W + OUT_W;   // {overflow, counter, aout}
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // ---------------- clock / reset ----------------
  logic             clock = 1'b0;
  logic             reset;
  logic [IN_W-1:0]  ain;
  logic [IN_W-1:0]  counter;
  logic             overflow;
  logic [OUT_W-1:0] aout;
  logic [1:0]       state_dbg;

  always #2 clock = ~clock;   // 4 ns period

  factorial #(.IN_W(IN_W), .OUT_W(OUT_W)) dut (
    .clock     (clock),
    .reset     (reset),
    .ain       (ain),
    .counter   (counter),
    .overflow  (overflow),
    .aout      (aout),
    .state_dbg (state_dbg)
  );

  // ---------------- scoreboard state ----------------
  int tests    = 0;
  int fails    = 0;
  int done_cnt = 0;
  logic [EXP_W-1:0] exp_q[$];
  logic [EXP_W-1:0] cur_exp;
  logic             cur_valid = 1'b0;
  logic [1:0]       prev_state = 2'd0;
  logic [IN_W-1:0]  last_n;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: multiply up from 1 while the product stays representable.
  function automatic logic [EXP_W-1:0] ref_model(input logic [IN_W-1:0] n);
    longint a   = 1;
    int     k   = 0;
    logic   ovf = 1'b0;
    longint lim = (longint'(1) << OUT_W) - 1;
    while ((k < int'(n)) && !ovf) begin
      if (a * (k + 1) > lim) ovf = 1'b1;
      else begin
        a = a * (k + 1);
        k++;
      end
    end
    return {ovf, k[IN_W-1:0], a[OUT_W-1:0]};
  endfunction

  function automatic logic [63:0] fact(input int k);
    longint a = 1;
    if (k > 20) return 64'hFFFF_FFFF_FFFF_FFFF;
    for (int i = 2; i <= k; i++) a = a * i;
    return a;
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clock) begin
    if (!reset) begin
      if (state_dbg == ST_CALC) begin
        check("calc_partial_product", aout, fact(int'(counter)));
        check("calc_overflow_low", overflow, 0);
      end
      if (state_dbg == ST_DONE && prev_state != ST_DONE) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          cur_exp   = exp_q.pop_front();
          cur_valid = 1'b1;
          done_cnt++;
        end
      end
      if (state_dbg == ST_DONE && cur_valid) begin
        check("done_aout", aout, cur_exp[OUT_W-1:0]);
        check("done_counter", counter, cur_exp[OUT_W+IN_W-1:OUT_W]);
        check("done_overflow", overflow, cur_exp[EXP_W-1]);
      end
    end
    prev_state = state_dbg;
  end

  // ---------------- driver tasks ----------------
  task automatic wait_done(input int target);
    int budget = 200;
    while (done_cnt < target && budget > 0) begin
      @(negedge clock);
      #1;
      budget--;
    end
    if (done_cnt < target) begin
      tests++;
      fails++;
      $display("FAIL done_timeout: got %0d results, expected %0d", done_cnt, target);
    end
  endtask

  task automatic apply(input logic [IN_W-1:0] n);
    int target;
    @(negedge clock);
    ain = n;
    last_n = n;
    exp_q.push_back(ref_model(n));
    target = done_cnt + 1;
    wait_done(target);
    repeat (3) @(negedge clock);   // a few held-result cycles
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int target;
    logic [IN_W-1:0] n;

    reset = 1'b1;
    ain   = 16'd4;
    last_n = 16'd4;
    repeat (2) @(posedge clock);
    #1;
    check("reset_aout", aout, 0);
    check("reset_counter", counter, 0);
    check("reset_overflow", overflow, 0);

    // ain=4: result visible after edge 5, then held
    @(negedge clock);
    exp_q.push_back(ref_model(16'd4));
    reset = 1'b0;
    repeat (5) @(posedge clock);
    #1;
    check("lat4_aout", aout, 24);
    check("lat4_counter", counter, 4);
    check("lat4_overflow", overflow, 0);
    wait_done(1);
    repeat (25) @(negedge clock);

    // Directed edge cases
    apply(16'd0);
    apply(16'd1);
    apply(16'd9);
    apply(16'd8);
    apply(16'd10);
    apply(16'd5);
    apply(16'hFFFF);
    apply(16'd2);

    // ain changes mid-CALC: finish on 6, then restart on 3
    @(negedge clock);
    ain = 16'd6;
    exp_q.push_back(ref_model(16'd6));
    exp_q.push_back(ref_model(16'd3));
    target = done_cnt + 2;
    repeat (3) @(negedge clock);
    ain = 16'd3;
    last_n = 16'd3;
    wait_done(target);
    repeat (3) @(negedge clock);

    // Asynchronous reset between edges during CALC
    @(negedge clock);
    ain = 16'd7;
    last_n = 16'd7;
    exp_q.push_back(ref_model(16'd7));
    repeat (4) @(posedge clock);
    #1;
    reset = 1'b1;
    #0.5;
    check("async_rst_aout", aout, 0);
    check("async_rst_counter", counter, 0);
    check("async_rst_overflow", overflow, 0);
    exp_q.delete();
    cur_valid = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    exp_q.push_back(ref_model(16'd7));
    wait_done(done_cnt + 1);
    repeat (3) @(negedge clock);

    // Randomized operands, always different from the latched one
    for (int i = 0; i < 16; i++) begin
      do begin
        if ($urandom_range(0, 4) == 0) n = IN_W'($urandom);
        else n = IN_W'($urandom_range(0, 12));
      end while (n == last_n);
      apply(n);
    end

    if (exp_q.size() != 0) check("leftover_expected", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global watchdog
  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got %0d results", done_cnt);
    $fatal(1, "watchdog expired");
  end

endmodule
